// File: rtl/mm_rd_burst_arbiter_pkg.sv
// Shared types and constants for the read-burst arbiter.
package mm_rd_burst_arbiter_pkg;

    localparam int unsigned NUM_MAX = 8;
    localparam int unsigned IDX_W   = $clog2(NUM_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Fold an index that may have run one lap past n back into 0..n-1.
    function automatic int unsigned idx_wrap(input int unsigned v, input int unsigned n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/mm_rd_burst_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping mod NUM.
module mm_rd_burst_arbiter_rr_pick
    import mm_rd_burst_arbiter_pkg::*;
#(
    parameter int unsigned NUM = 4
) (
    input  logic [NUM-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM-1:0]   win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    // Scan offsets from the pointer; constant bit indices keep the search shallow.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int unsigned k = 0; k < NUM; k++) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                if (!win_vld && req[i] && (idx_wrap(32'(ptr) + k, NUM) == i)) begin
                    win_vld    = 1'b1;
                    win_oh[i]  = 1'b1;
                    win_idx    = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mm_rd_burst_arbiter.sv
// Shares one AXI read-core request port among NUM video read channels,
// one transaction in flight, with a done-watchdog and rvalid steering.
module mm_rd_burst_arbiter
    import mm_rd_burst_arbiter_pkg::*;
#(
    parameter int unsigned NUM     = 4,
    parameter int unsigned ASIZE   = 29,
    parameter int unsigned LSIZE   = 9,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                 axi_aclk,
    input  logic                 rst,
    input  logic [NUM-1:0]       ch_req,
    input  logic [NUM*LSIZE-1:0] ch_len,
    input  logic [NUM*ASIZE-1:0] ch_addr,
    output logic [NUM-1:0]       ch_resp,
    output logic [NUM-1:0]       ch_done,
    output logic [NUM-1:0]       ch_rvalid,
    output logic                 core_req,
    output logic [LSIZE-1:0]     core_len,
    output logic [ASIZE-1:0]     core_addr,
    input  logic                 core_resp,
    input  logic                 core_done,
    input  logic                 axi_rvalid,
    output logic [NUM-1:0]       grant,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] ptr_next;
    logic [WD_W-1:0]  wd_cnt;
    logic             wd_hit;

    logic [NUM-1:0]   pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [LSIZE-1:0] sel_len;
    logic [ASIZE-1:0] sel_addr;

    mm_rd_burst_arbiter_rr_pick #(.NUM(NUM)) u_pick (
        .req     (ch_req),
        .ptr     (ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    // Select the winner's length and address for latching.
    always_comb begin
        sel_len  = '0;
        sel_addr = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            if (pick_oh[i]) begin
                sel_len  = ch_len[i*LSIZE +: LSIZE];
                sel_addr = ch_addr[i*ASIZE +: ASIZE];
            end
        end
    end

    assign ptr_next  = IDX_W'(idx_wrap(32'(gidx) + 1, NUM));
    assign wd_hit    = (TIMEOUT > 0) && (wd_cnt == WD_LAST);
    assign busy      = (state != ST_IDLE);
    assign ch_rvalid = grant & {NUM{axi_rvalid}};

    // Arbitration FSM with latched request, pointer advance and watchdog.
    always_ff @(posedge axi_aclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gidx      <= '0;
            wd_cnt    <= '0;
            core_req  <= 1'b0;
            core_len  <= '0;
            core_addr <= '0;
            grant     <= '0;
            ch_resp   <= '0;
            ch_done   <= '0;
            err       <= 1'b0;
        end else begin
            ch_resp <= '0;
            ch_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant     <= pick_oh;
                        gidx      <= pick_idx;
                        core_len  <= sel_len;
                        core_addr <= sel_addr;
                        core_req  <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (core_resp) begin
                        core_req <= 1'b0;
                        ch_resp  <= grant;
                        wd_cnt   <= '0;
                        if (core_done) begin
                            ch_done <= grant;
                            grant   <= '0;
                            ptr     <= ptr_next;
                            state   <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (core_done || wd_hit) begin
                        ch_done <= grant;
                        grant   <= '0;
                        ptr     <= ptr_next;
                        state   <= ST_IDLE;
                        if (!core_done) begin
                            err <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_rd_burst_arbiter.sv
// Self-checking bench for mm_rd_burst_arbiter.
module tb_mm_rd_burst_arbiter;

    localparam int unsigned NUM     = 4;
    localparam int unsigned ASIZE   = 29;
    localparam int unsigned LSIZE   = 9;
    localparam int unsigned TIMEOUT = 256;
    localparam int          NVEC    = 12;

    logic                 axi_aclk = 1'b0;
    logic                 rst;
    logic [NUM-1:0]       ch_req;
    logic [NUM*LSIZE-1:0] ch_len;
    logic [NUM*ASIZE-1:0] ch_addr;
    logic [NUM-1:0]       ch_resp, ch_done, ch_rvalid, grant;
    logic                 core_req, core_resp, core_done, axi_rvalid, busy, err;
    logic [LSIZE-1:0]     core_len;
    logic [ASIZE-1:0]     core_addr;

    mm_rd_burst_arbiter #(.NUM(NUM), .ASIZE(ASIZE), .LSIZE(LSIZE), .TIMEOUT(TIMEOUT)) dut (
        .axi_aclk   (axi_aclk),
        .rst        (rst),
        .ch_req     (ch_req),
        .ch_len     (ch_len),
        .ch_addr    (ch_addr),
        .ch_resp    (ch_resp),
        .ch_done    (ch_done),
        .ch_rvalid  (ch_rvalid),
        .core_req   (core_req),
        .core_len   (core_len),
        .core_addr  (core_addr),
        .core_resp  (core_resp),
        .core_done  (core_done),
        .axi_rvalid (axi_rvalid),
        .grant      (grant),
        .busy       (busy),
        .err        (err)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic [NUM-1:0]   grant;
        logic [LSIZE-1:0] len;
        logic [ASIZE-1:0] addr;
    } exp_t;

    typedef struct {
        logic [NUM-1:0] mask;
        int             ch;
        int             resp_dly;
        int             done_dly;
        bit             same;
        int             beats;
    } vec_t;

    exp_t             sb[$];
    vec_t             vecs[NVEC];
    logic [LSIZE-1:0] lens[NUM];
    logic [ASIZE-1:0] addrs[NUM];
    int               rv_cnt[NUM] = '{default: 0};
    int               snap[NUM];
    logic             prev_req = 1'b0;
    int               n_checks = 0;
    int               n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM-1:0] oh(input int ch);
        return NUM'(1) << ch;
    endfunction

    task automatic nx();
        @(negedge axi_aclk);
        #1;
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.grant = oh(ch);
        e.len   = lens[ch];
        e.addr  = addrs[ch];
        sb.push_back(e);
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            nx();
            if (core_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("core_req_rise", 64'(seen), 1);
    endtask

    // Scoreboard: every core_req rising edge must match the oldest expectation.
    always @(negedge axi_aclk) begin
        exp_t e;
        if (rst) begin
            prev_req <= 1'b0;
        end else begin
            for (int i = 0; i < NUM; i++)
                if (ch_rvalid[i]) rv_cnt[i] <= rv_cnt[i] + 1;
            if (core_req && !prev_req) begin
                check("sb_nonempty", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_grant", grant, e.grant);
                    check("sb_len", core_len, e.len);
                    check("sb_addr", core_addr, e.addr);
                end
            end
            prev_req <= core_req;
        end
    end

    // One full transaction for the currently-expected channel.
    task automatic do_txn(input int ch, input int resp_dly, input int done_dly, input bit same,
                          input int beats, input logic [NUM-1:0] next_mask, input int next_ch);
        bit seen;
        int sent;
        int cyc;
        wait_req(seen);
        if (!seen) return;
        check("grant_issue", grant, oh(ch));
        check("busy_issue", busy, 1);
        repeat (resp_dly) begin
            nx();
            check("core_req_hold", core_req, 1);
        end
        core_resp = 1'b1;
        core_done = same;
        nx();
        core_resp = 1'b0;
        core_done = 1'b0;
        check("ch_resp", ch_resp, oh(ch));
        check("core_req_drop", core_req, 0);
        check("ch_done_with_resp", ch_done, same ? oh(ch) : '0);
        ch_req = next_mask;
        if (next_ch >= 0) push(next_ch);
        if (!same) begin
            sent = 0;
            cyc  = 0;
            while (sent < beats) begin
                axi_rvalid = (cyc % 8 != 7);
                if (axi_rvalid) sent++;
                cyc++;
                nx();
            end
            axi_rvalid = 1'b0;
            repeat (done_dly) begin
                nx();
                check("wait_quiet", {ch_done, core_req}, 0);
            end
            core_done = 1'b1;
            nx();
            core_done = 1'b0;
            check("ch_done", ch_done, oh(ch));
        end
        check("grant_clear", grant, 0);
        check("busy_clear", busy, 0);
        check("idle_gap", core_req, 0);
        nx();
        check("pulse_end", {ch_resp, ch_done}, 0);
        check("next_core_req", core_req, 64'(next_mask != 0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit seen;
        bit early;
        logic [NUM-1:0] nm;
        int nc;

        lens  = '{9'd17, 9'd0, 9'd200, 9'd511};
        addrs = '{29'h0ABC000, 29'h1FFFFFFF, 29'h0001000, 29'h0123456};
        for (int i = 0; i < NUM; i++) begin
            ch_len[i*LSIZE +: LSIZE]  = lens[i];
            ch_addr[i*ASIZE +: ASIZE] = addrs[i];
        end

        //              mask     ch resp done same beats
        vecs[0]  = '{4'b1111, 0, 0, 0, 1'b0, 0};
        vecs[1]  = '{4'b1111, 1, 2, 3, 1'b0, 0};
        vecs[2]  = '{4'b1111, 2, 1, 0, 1'b1, 0};
        vecs[3]  = '{4'b1111, 3, 0, 5, 1'b0, 0};
        vecs[4]  = '{4'b1111, 0, 3, 1, 1'b0, 0};
        vecs[5]  = '{4'b0001, 0, 0, 0, 1'b1, 0};
        vecs[6]  = '{4'b1000, 3, 1, 2, 1'b0, 0};
        vecs[7]  = '{4'b0110, 1, 0, 1, 1'b0, 0};
        vecs[8]  = '{4'b0011, 0, 2, 0, 1'b0, 0};
        vecs[9]  = '{4'b0100, 2, 0, 0, 1'b1, 0};
        vecs[10] = '{4'b1001, 3, 1, 1, 1'b0, 0};
        vecs[11] = '{4'b0110, 1, 0, 0, 1'b0, 200};

        rst = 1'b1; ch_req = '0; core_resp = 1'b0; core_done = 1'b0; axi_rvalid = 1'b0;
        repeat (3) nx();
        check("rst_core_req", core_req, 0);
        check("rst_grant", grant, 0);
        check("rst_pulses", {ch_resp, ch_done}, 0);
        check("rst_busy_err", {busy, err}, 0);
        check("rst_len_addr", {core_len, core_addr}, 0);

        // Table-driven transactions, next row's request driven after ch_resp.
        rst = 1'b0;
        ch_req = vecs[0].mask;
        push(vecs[0].ch);
        for (int i = 0; i < NVEC; i++) begin
            nm = (i + 1 < NVEC) ? vecs[i+1].mask : '0;
            nc = (i + 1 < NVEC) ? vecs[i+1].ch : -1;
            for (int j = 0; j < NUM; j++) snap[j] = rv_cnt[j];
            do_txn(vecs[i].ch, vecs[i].resp_dly, vecs[i].done_dly, vecs[i].same, vecs[i].beats, nm, nc);
            if (vecs[i].beats > 0)
                for (int j = 0; j < NUM; j++)
                    check("rvalid_count", 64'(rv_cnt[j] - snap[j]), (j == vecs[i].ch) ? 64'(vecs[i].beats) : 0);
        end

        // rvalid while idle goes nowhere.
        for (int j = 0; j < NUM; j++) snap[j] = rv_cnt[j];
        axi_rvalid = 1'b1;
        repeat (5) begin
            nx();
            check("idle_rvalid", ch_rvalid, 0);
        end
        axi_rvalid = 1'b0;
        nx();
        for (int j = 0; j < NUM; j++) check("idle_rvalid_count", 64'(rv_cnt[j]), 64'(snap[j]));

        // Watchdog: pointer at 2, channel 2 never completes.
        ch_req = 4'b0110;
        push(2);
        wait_req(seen);
        check("wd_grant", grant, 4'b0100);
        core_resp = 1'b1;
        nx();
        core_resp = 1'b0;
        check("wd_ch_resp", ch_resp, 4'b0100);
        early = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            nx();
            if (err || (ch_done != 0) || !busy) early = 1'b1;
        end
        check("wd_no_early", 64'(early), 0);
        nx();
        check("wd_err", err, 1);
        check("wd_ch_done", ch_done, 4'b0100);
        check("wd_grant_clear", grant, 0);
        push(1);
        do_txn(1, 0, 2, 1'b0, 0, '0, -1);
        check("wd_err_sticky", err, 1);
        core_done = 1'b1;
        nx();
        core_done = 1'b0;
        nx();
        check("stray_done", {ch_done, busy, core_req}, 0);
        check("stray_err_sticky", err, 1);

        // Single request, one-cycle latency; pointer then lands on 3.
        check("lat_idle", core_req, 0);
        ch_req = 4'b0100;
        push(2);
        nx();
        check("lat_core_req", core_req, 1);
        check("lat_grant", grant, 4'b0100);
        do_txn(2, 1, 2, 1'b0, 0, 4'b1011, 3);

        // Reset while channel 3 waits for done.
        check("rst_test_grant", grant, 4'b1000);
        core_resp = 1'b1;
        nx();
        core_resp = 1'b0;
        check("rst_test_resp", ch_resp, 4'b1000);
        repeat (3) nx();
        axi_rvalid = 1'b1;
        rst = 1'b1;
        #1;
        check("async_rst_grant_req", {grant, core_req}, 0);
        check("async_rst_busy_err", {busy, err}, 0);
        check("async_rst_rvalid", ch_rvalid, 0);
        check("async_rst_len_addr", {core_len, core_addr}, 0);
        nx();
        nx();
        rst = 1'b0;
        axi_rvalid = 1'b0;
        ch_req = 4'b1001;
        push(0);
        do_txn(0, 0, 1, 1'b0, 0, '0, -1);
        nx();
        check("sb_drained", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
